mdu_divider: RTL and testbench
==============================

# mdu_divider

Iterative 32-bit signed/unsigned divider for the multicycle MIPS core, executing DIV and DIVU. It sits directly downstream of the register file: its operands are the rs and rt read-port outputs, and the controller writes its quotient and remainder into LO and HI. From there, MFLO and MFHI return the results to the register file. It produces one quotient bit per clock and uses a start/busy/done handshake so the controller can stall.

## Interface
- No parameters; the datapath width is fixed at 32.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  request a division; sampled on the rising edge.
- iSigned  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with iStart.
- iDividend  in  32  dividend; the rs read data.
- iDivisor  in  32  divisor; the rt read data.
- oBusy  out  1  high while a division is in progress.
- oDone  out  1  one-cycle pulse; results are valid from this cycle onward.
- oQuotient  out  32  quotient, destined for LO.
- oRemainder  out  32  remainder, destined for HI.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Acceptance:
  - iStart is accepted only in IDLE or DONE. It is ignored in RUN and FIX.
  - On accept, latch the operand magnitudes, latch the sign flags (signed mode only), clear the 32-bit partial remainder, set the 5-bit counter to 0, and go to RUN.
  - Operands are not sampled again after acceptance.
- Magnitude rule: |x| is the 32-bit two's-complement negation when the sign bit is set. |0x80000000| = 0x80000000, interpreted as unsigned.
- RUN, one restoring step per cycle:
  - Form the 33-bit trial value {rem, dvd[31]} − {1'b0, dvs}.
  - If the result is non-negative, rem takes the result and the quotient bit is 1. Otherwise rem takes {rem[30:0], dvd[31]} and the quotient bit is 0.
  - Shift dvd left, inserting the quotient bit.
  - When the counter reaches 31, go to FIX.
- FIX:
  - Signed mode: negate the quotient if the operand signs differ, and negate the remainder if the dividend is negative.
  - Load oQuotient and oRemainder, then go to DONE.
- DONE: oDone = 1 for this single cycle. The next state is IDLE, or RUN if iStart is accepted in this cycle.
- Signed results: the quotient truncates toward zero, and the remainder takes the sign of the dividend.
- Divisor = 0, either mode: oQuotient = 32'hFFFFFFFF and oRemainder = iDividend. This is the natural result of the algorithm plus the sign fix, forced explicitly for the signed case.
- Signed 0x80000000 / 0xFFFFFFFF: oQuotient = 0x80000000, oRemainder = 0. No trap is raised.
- oQuotient and oRemainder hold their values from FIX until the next FIX. They are not cleared on a new start.

## Timing
- Reset values: oBusy = 0, oDone = 0, oQuotient = 0, oRemainder = 0. The state is IDLE and the counter is 0.
- Cycle-level sequence, with edge E0 as the edge that accepts iStart:
  - E1–E32: RUN steps.
  - E33: FIX.
  - Cycle after E33: oDone = 1.
- Latency from the accepting edge to oDone is 34 cycles.
- oBusy = 1 exactly while the state is RUN or FIX, i.e. from after E0 to E33. oBusy is 0 in DONE.
- Back-to-back operation: iStart high during the DONE cycle is accepted at that edge, with no idle gap.
- Reset asserted mid-operation: all outputs and state return to reset values immediately (asynchronously). The partial result is discarded and no oDone is issued.
- Outputs are fully registered. There is no combinational path from the inputs to any output.

## Test plan
- Unsigned 100 / 7 → oQuotient = 14, oRemainder = 2. oDone is high exactly 34 cycles after the accepting edge, and oBusy is high for 33 cycles.
- Signed 0xFFFFFFF9 (−7) / 2 → oQuotient = 0xFFFFFFFD (−3), oRemainder = 0xFFFFFFFF (−1). Unsigned on the same operands → oQuotient = 0x7FFFFFFC, oRemainder = 1.
- Signed 0x80000000 / 0xFFFFFFFF → oQuotient = 0x80000000, oRemainder = 0. Divisor 0 with dividend 0x12345678, both modes → oQuotient = 0xFFFFFFFF, oRemainder = 0x12345678.
- Pulse iStart and change the operands at cycle 10 of RUN → ignored. The original result completes on schedule.
- Back-to-back: iStart asserted in the DONE cycle with 9 / 3 → second oDone 34 cycles later, with oQuotient = 3 and oRemainder = 0.
- Assert rst at cycle 15 of RUN → all outputs are 0 and oBusy is 0 immediately, with no oDone. After release, a new 50 / 5 gives 10 r 0.

Source files
------------

// File: rtl/mdu_divider.sv
// Iterative 32-bit restoring divider for DIV/DIVU: one quotient bit per cycle,
// start/busy/done handshake, quotient destined for LO and remainder for HI.
module mdu_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        iStart,
    input  logic        iSigned,
    input  logic [31:0] iDividend,
    input  logic [31:0] iDivisor,
    output logic        oBusy,
    output logic        oDone,
    output logic [31:0] oQuotient,
    output logic [31:0] oRemainder
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q, dvs_q, rem_q;
    logic        negq_q, negr_q;
    logic        busy_q, done_q;
    logic [31:0] quot_q, remo_q;

    logic        accept;
    logic [31:0] mag_a, mag_b;
    logic [32:0] trial;
    logic        qbit;
    logic [31:0] rem_d, dvd_d, quot_d, remo_d;

    always_comb begin
        accept = iStart && (state_q == IDLE || state_q == DONE);
        mag_a  = (iSigned && iDividend[31]) ? (~iDividend + 32'd1) : iDividend;
        mag_b  = (iSigned && iDivisor[31])  ? (~iDivisor + 32'd1)  : iDivisor;

        trial  = {rem_q, dvd_q[31]} - {1'b0, dvs_q};
        qbit   = ~trial[32];
        rem_d  = qbit ? trial[31:0] : {rem_q[30:0], dvd_q[31]};
        dvd_d  = {dvd_q[30:0], qbit};

        // A zero divisor must yield all-ones even when the sign fix would negate it.
        quot_d = negq_q ? (~dvd_q + 32'd1) : dvd_q;
        if (dvs_q == '0) quot_d = '1;
        remo_d = negr_q ? (~rem_q + 32'd1) : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        dvd_q   <= mag_a;
                        dvs_q   <= mag_b;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        negq_q  <= iSigned & (iDividend[31] ^ iDivisor[31]);
                        negr_q  <= iSigned & iDividend[31];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    rem_q <= rem_d;
                    dvd_q <= dvd_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    quot_q  <= quot_d;
                    remo_q  <= remo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oBusy      = busy_q;
    assign oDone      = done_q;
    assign oQuotient  = quot_q;
    assign oRemainder = remo_q;

endmodule

// File: tb/tb_mdu_divider.sv
// Scoreboard bench for mdu_divider: directed corner cases plus random operands
// checked against plain-arithmetic division semantics of DIV/DIVU.
module tb_mdu_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStart, iSigned;
    logic [31:0] iDividend, iDivisor;
    logic        oBusy, oDone;
    logic [31:0] oQuotient, oRemainder;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    mdu_divider dut (
        .clk        (clk),
        .rst        (rst),
        .iStart     (iStart),
        .iSigned    (iSigned),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // {quotient, remainder}; signed divide truncates toward zero in SV
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (!s) return {a / b, a % b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'd0};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (oDone === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got oDone=1 expected no result pending");
                end else begin
                    e = sb_q.pop_front();
                    check("quotient", oQuotient, e[63:32]);
                    check("remainder", oRemainder, e[31:0]);
                end
            end
        end
    end

    // Called at a negedge; the next rising edge is the accepting edge.
    // Returns at the negedge in which oDone is observed (the DONE cycle).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int interfere);
        int n, busy;
        iDividend = a;
        iDivisor  = b;
        iSigned   = s;
        iStart    = 1'b1;
        sb_q.push_back(ref_div(a, b, s));
        @(negedge clk);
        iStart = 1'b0;
        n = 1;
        busy = 0;
        while (oDone !== 1'b1 && n < 60) begin
            if (oBusy === 1'b1) busy++;
            if (n == interfere) begin
                iStart    = 1'b1;
                iDividend = $urandom;
                iDivisor  = $urandom;
                iSigned   = ~s;
            end else begin
                iStart = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd34);
        check("busy_cycles", 32'(busy), 32'd33);
        check("busy_in_done", 32'(oBusy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        iStart = 1'b0;
        iSigned = 1'b0;
        iDividend = '0;
        iDivisor = '0;
        #1;
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_done", 32'(oDone), 32'd0);
        check("rst_quot", oQuotient, 32'd0);
        check("rst_rem", oRemainder, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        do_op(32'd100, 32'd7, 1'b0, -1);
        check("q_100_7", oQuotient, 32'd14);
        check("r_100_7", oRemainder, 32'd2);
        @(negedge clk);
        check("done_one_cycle", 32'(oDone), 32'd0);

        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1);
        check("q_m7_2_s", oQuotient, 32'hFFFF_FFFD);
        check("r_m7_2_s", oRemainder, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, -1);
        check("q_m7_2_u", oQuotient, 32'h7FFF_FFFC);
        check("r_m7_2_u", oRemainder, 32'd1);
        @(negedge clk);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        check("q_ovf", oQuotient, 32'h8000_0000);
        check("r_ovf", oRemainder, 32'd0);
        @(negedge clk);
        do_op(32'h1234_5678, 32'd0, 1'b0, -1);
        check("q_div0_u", oQuotient, 32'hFFFF_FFFF);
        @(negedge clk);
        do_op(32'h1234_5678, 32'd0, 1'b1, -1);
        check("q_div0_s", oQuotient, 32'hFFFF_FFFF);
        check("r_div0_s", oRemainder, 32'h1234_5678);
        @(negedge clk);

        // start pulse with new operands mid-run must be ignored; then back-to-back
        do_op(32'd1000, 32'd7, 1'b0, 10);
        check("q_ignored_start", oQuotient, 32'd142);
        do_op(32'd9, 32'd3, 1'b0, -1);
        check("q_b2b", oQuotient, 32'd3);
        check("r_b2b", oRemainder, 32'd0);
        @(negedge clk);

        // asynchronous reset partway through a run
        iDividend = 32'd1000;
        iDivisor  = 32'd3;
        iSigned   = 1'b0;
        iStart    = 1'b1;
        @(negedge clk);
        iStart = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(oBusy), 32'd0);
        check("arst_done", 32'(oDone), 32'd0);
        check("arst_quot", oQuotient, 32'd0);
        check("arst_rem", oRemainder, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", 32'(oBusy), 32'd0);
        do_op(32'd50, 32'd5, 1'b0, -1);
        check("q_50_5", oQuotient, 32'd10);
        check("r_50_5", oRemainder, 32'd0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            do_op(pick(), pick(), 1'($urandom_range(0, 1)), -1);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
